led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Registered front-panel LED driver. Turns the raw readiness signals (Aurora link, ADC-acquisition
//  and command SM idles) into timed, human-visible patterns. Adds a power-on lamp test, busy
//  stretching with blinking, and numeric error-code blinking. Drives the active-low red/green pins.
// PARAMETERS
//  TICK_DIV         12_500_000  clk cycles per tick (100 ms @125 MHz); >=2
//  LAMP_TEST_TICKS  10          ticks both LEDs lit after reset release
//  STRETCH_TICKS    2           min ticks busy is held after the raw busy condition ends
//  GAP_TICKS        10          dark ticks after an error-code burst
// PORTS
//  clk                input   1  system clock
//  rst_n              input   1  asynchronous active-low reset
//  aurora_channel_up  input   1  link status, asynchronous to clk
//  adc_acq_sm_idle    input   1  ADC acquisition SM idle, clk domain
//  command_sm_idle    input   1  command SM idle, clk domain
//  err_pulse          input   1  1-cycle strobe: err_code valid
//  err_code           input   4  error number 1..15 (0 = ignore)
//  red_led            output  1  active low (0 = on)
//  green_led          output  1  active low (0 = on)
// BEHAVIOUR
//  Reset: all flops cleared; red_led=0, green_led=0 (both lit); state=LAMP; prescaler=0.
//  Sync: aurora_channel_up -> 2-FF synchronizer (reset 0) = link_s. Idle inputs used directly.
//  Prescaler: counts 0..TICK_DIV-1; tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
//   Cleared to 0 on every entry to ERR_ON, so each error phase lasts exactly TICK_DIV cycles.
//  Busy stretch: busy_raw = ~(adc_acq_sm_idle & command_sm_idle). Counter loads STRETCH_TICKS
//   on any cycle busy_raw=1; else decrements on tick, saturates at 0. busy_s = busy_raw | (cnt!=0).
//  Blink flop: toggles on tick while busy_s=1; cleared when busy_s=0.
//  States (priority LAMP > ERR_* > normal):
//   LAMP   : both lit; count LAMP_TEST_TICKS ticks -> RUN. err_pulse ignored.
//   RUN    : link_s=0 -> red on, green off.  link_s=1 & busy_s -> red off, green = blink.
//            link_s=1 & ~busy_s -> green on, red off.
//            err_pulse & err_code!=0 -> latch code into cnt_e, -> ERR_ON (same edge).
//   ERR_ON : red on, green off, 1 tick -> ERR_OFF.
//   ERR_OFF: both off, 1 tick; cnt_e-1; if result 0 -> ERR_GAP else ERR_ON.
//   ERR_GAP: both off, GAP_TICKS ticks -> RUN.
//  err_pulse with err_code=0, or any err_pulse outside RUN: dropped (no queue).
//  err_pulse and link/busy changes on same cycle: error entry wins; link/busy only affect RUN.
//  Outputs registered: LED pins update 1 cycle after state/blink change; link edge -> pin in 3 clk
//   (2 sync + 1 output reg); idle edge -> pin in 1 clk (busy rising); busy falling -> green solid
//   after the stretch expires (STRETCH_TICKS ticks, partial first tick allowed).
//  Reset asserted mid-sequence: immediate return to reset values; sequence discarded, LAMP restarts.
//  Invariant: red_led and green_led never both 0 outside LAMP.
// TESTING (bench params TICK_DIV=4, LAMP_TEST_TICKS=2, STRETCH_TICKS=2, GAP_TICKS=3)
//  1 Release rst_n, link=1, idles=1 -> red=0,green=0 for 8 clk, then green=0,red=1 solid.
//  2 After lamp, drop aurora_channel_up -> red=0,green=1 exactly 3 clk later; raise it -> green on in 3 clk.
//  3 Link up, pulse adc_acq_sm_idle low 1 clk -> green toggles every 4 clk, stays busy >=8 clk, then solid.
//  4 In RUN, err_pulse with err_code=3 -> red on 4/off 4 x3 (24 clk) then both off 12 clk, back to RUN.
//  5 err_pulse err_code=0, and err_pulse(code 5) during LAMP and during ERR_ON -> no pattern change.
//  6 Assert rst_n low during ERR_OFF -> both LEDs 0 asynchronously; after release, full LAMP replays.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Front-panel LED driver: lamp test after reset, link/busy indication with busy
// stretching and blinking, and numeric error-code blinking on active-low pins.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_LAMP    | both LEDs lit for LAMP_TEST_TICKS ticks after reset release
// S_RUN     | normal indication from link and busy; accepts error codes
// S_ERR_ON  | red lit for one tick (one blink of the error code)
// S_ERR_OFF | both dark for one tick; counts down the remaining blinks
// S_ERR_GAP | both dark for GAP_TICKS ticks before returning to S_RUN
module led_pattern_ctrl #(
  parameter int TICK_DIV        = 12_500_000,
  parameter int LAMP_TEST_TICKS = 10,
  parameter int STRETCH_TICKS   = 2,
  parameter int GAP_TICKS       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       aurora_channel_up,
  input  logic       adc_acq_sm_idle,
  input  logic       command_sm_idle,
  input  logic       err_pulse,
  input  logic [3:0] err_code,
  output logic       red_led,
  output logic       green_led
);

  localparam int PW   = $clog2(TICK_DIV);
  localparam int SW   = (STRETCH_TICKS < 1) ? 1 : $clog2(STRETCH_TICKS + 1);
  localparam int TMAX = (LAMP_TEST_TICKS > GAP_TICKS) ? LAMP_TEST_TICKS : GAP_TICKS;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [PW-1:0] P_LAST       = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);
  localparam logic [TW-1:0] LAMP_LAST    = TW'(LAMP_TEST_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_LAMP,
    S_RUN,
    S_ERR_ON,
    S_ERR_OFF,
    S_ERR_GAP
  } state_t;

  state_t          state;
  logic            link_m;
  logic            link_s;
  logic [PW-1:0]   cnt_p;
  logic [SW-1:0]   cnt_b;
  logic [TW-1:0]   cnt_t;
  logic [3:0]      cnt_e;
  logic            blink;
  logic            tick;
  logic            busy_raw;
  logic            busy_s;
  logic            err_take;

  assign tick     = (cnt_p == P_LAST);
  assign busy_raw = ~(adc_acq_sm_idle & command_sm_idle);
  assign busy_s   = busy_raw | (cnt_b != '0);
  assign err_take = (state == S_RUN) & err_pulse & (err_code != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_m <= 1'b0;
      link_s <= 1'b0;
    end else begin
      link_m <= aurora_channel_up;
      link_s <= link_m;
    end
  end

  // Restarting on error entry makes every blink phase a full tick long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_p <= '0;
    else if (err_take || tick)
      cnt_p <= '0;
    else
      cnt_p <= cnt_p + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_b <= '0;
      blink <= 1'b0;
    end else begin
      if (busy_raw)
        cnt_b <= STRETCH_LOAD;
      else if (tick && (cnt_b != '0))
        cnt_b <= cnt_b - 1'b1;

      if (!busy_s)
        blink <= 1'b0;
      else if (tick)
        blink <= ~blink;
    end
  end

  // Pins are driven from the current state, so they trail a transition by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_LAMP;
      cnt_t     <= '0;
      cnt_e     <= '0;
      red_led   <= 1'b0;
      green_led <= 1'b0;
    end else begin
      case (state)
        S_LAMP: begin
          red_led   <= 1'b0;
          green_led <= 1'b0;
          if (tick) begin
            if (cnt_t == LAMP_LAST) begin
              cnt_t <= '0;
              state <= S_RUN;
            end else begin
              cnt_t <= cnt_t + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!link_s) begin
            red_led   <= 1'b0;
            green_led <= 1'b1;
          end else if (busy_s) begin
            red_led   <= 1'b1;
            green_led <= ~blink;
          end else begin
            red_led   <= 1'b1;
            green_led <= 1'b0;
          end
          if (err_take) begin
            cnt_e <= err_code;
            state <= S_ERR_ON;
          end
        end
        S_ERR_ON: begin
          red_led   <= 1'b0;
          green_led <= 1'b1;
          if (tick)
            state <= S_ERR_OFF;
        end
        S_ERR_OFF: begin
          red_led   <= 1'b1;
          green_led <= 1'b1;
          if (tick) begin
            cnt_e <= cnt_e - 4'd1;
            state <= (cnt_e == 4'd1) ? S_ERR_GAP : S_ERR_ON;
          end
        end
        S_ERR_GAP: begin
          red_led   <= 1'b1;
          green_led <= 1'b1;
          if (tick) begin
            if (cnt_t == GAP_LAST) begin
              cnt_t <= '0;
              state <= S_RUN;
            end else begin
              cnt_t <= cnt_t + 1'b1;
            end
          end
        end
        default: begin
          red_led   <= 1'b1;
          green_led <= 1'b1;
          cnt_t     <= '0;
          state     <= S_LAMP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: per-cycle run-length vectors from reset
// release, plus a hand-written asynchronous reset in the middle of an error burst.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       aurora_channel_up;
  logic       adc_acq_sm_idle;
  logic       command_sm_idle;
  logic       err_pulse;
  logic [3:0] err_code;
  logic       red_led;
  logic       green_led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       link;
    logic       adc_idle;
    logic       cmd_idle;
    logic       ep;
    logic [3:0] code;
    int         n;
    logic       red;
    logic       green;
  } vec_t;

  vec_t vecs[$];

  led_pattern_ctrl #(
    .TICK_DIV        (4),
    .LAMP_TEST_TICKS (2),
    .STRETCH_TICKS   (2),
    .GAP_TICKS       (3)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .aurora_channel_up (aurora_channel_up),
    .adc_acq_sm_idle   (adc_acq_sm_idle),
    .command_sm_idle   (command_sm_idle),
    .err_pulse         (err_pulse),
    .err_code          (err_code),
    .red_led           (red_led),
    .green_led         (green_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic link, input logic adc_idle, input logic cmd_idle,
                              input logic ep, input logic [3:0] code, input int n,
                              input logic red, input logic green);
    vec_t v;
    v.link = link; v.adc_idle = adc_idle; v.cmd_idle = cmd_idle;
    v.ep = ep; v.code = code; v.n = n; v.red = red; v.green = green;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic red_exp, input logic green_exp);
    checks++;
    if (red_led !== red_exp || green_led !== green_exp) begin
      errors++;
      $display("FAIL %s: red/green got %b/%b want %b/%b at %0t",
               name, red_led, green_led, red_exp, green_exp, $time);
    end
  endtask

  // Each record holds its inputs for n cycles; outputs checked 1 time unit after every edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        aurora_channel_up = vecs[i].link;
        adc_acq_sm_idle   = vecs[i].adc_idle;
        command_sm_idle   = vecs[i].cmd_idle;
        err_pulse         = vecs[i].ep;
        err_code          = vecs[i].code;
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d.%0d", i, j), vecs[i].red, vecs[i].green);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    // Lamp test, then link drop/raise (3-cycle latency)
    add(1, 1, 1, 0, 0,  8, 0, 0);   // 0
    add(1, 1, 1, 0, 0,  4, 1, 0);   // 1
    add(0, 1, 1, 0, 0,  2, 1, 0);   // 2
    add(0, 1, 1, 0, 0,  6, 0, 1);   // 3
    add(1, 1, 1, 0, 0,  2, 0, 1);   // 4
    add(1, 1, 1, 0, 0,  2, 1, 0);   // 5
    // One-cycle busy pulse, then a long busy with blinking and stretch
    add(1, 0, 1, 0, 0,  1, 1, 1);   // 6
    add(1, 1, 1, 0, 0,  3, 1, 1);   // 7
    add(1, 1, 1, 0, 0,  4, 1, 0);   // 8
    add(1, 1, 0, 0, 0,  4, 1, 1);   // 9
    add(1, 1, 0, 0, 0,  4, 1, 0);   // 10
    add(1, 1, 0, 0, 0,  2, 1, 1);   // 11
    add(1, 1, 1, 0, 0,  2, 1, 1);   // 12
    add(1, 1, 1, 0, 0,  8, 1, 0);   // 13
    // Error code 3: three red blinks then a 12-cycle gap
    add(1, 1, 1, 1, 3,  1, 1, 0);   // 14
    add(1, 1, 1, 0, 0,  4, 0, 1);   // 15
    add(1, 1, 1, 0, 0,  4, 1, 1);   // 16
    add(1, 1, 1, 0, 0,  4, 0, 1);   // 17
    add(1, 1, 1, 0, 0,  4, 1, 1);   // 18
    add(1, 1, 1, 0, 0,  4, 0, 1);   // 19
    add(1, 1, 1, 0, 0,  4, 1, 1);   // 20
    add(1, 1, 1, 0, 0, 12, 1, 1);   // 21
    add(1, 1, 1, 0, 0,  2, 1, 0);   // 22
    // Code 0 ignored; code 1 accepted; code 5 during ERR_ON dropped
    add(1, 1, 1, 1, 0,  1, 1, 0);   // 23
    add(1, 1, 1, 0, 0,  1, 1, 0);   // 24
    add(1, 1, 1, 1, 1,  1, 1, 0);   // 25
    add(1, 1, 1, 0, 0,  1, 0, 1);   // 26
    add(1, 1, 1, 1, 5,  1, 0, 1);   // 27
    add(1, 1, 1, 0, 0,  2, 0, 1);   // 28
    add(1, 1, 1, 0, 0,  4, 1, 1);   // 29
    add(1, 1, 1, 0, 0, 12, 1, 1);   // 30
    add(1, 1, 1, 0, 0,  2, 1, 0);   // 31
    // Code 2, stop partway into the first ERR_OFF
    add(1, 1, 1, 1, 2,  1, 1, 0);   // 32
    add(1, 1, 1, 0, 0,  4, 0, 1);   // 33
    add(1, 1, 1, 0, 0,  2, 1, 1);   // 34
    // After reset: full lamp replays, err_pulse during lamp dropped
    add(1, 1, 1, 0, 0,  2, 0, 0);   // 35
    add(1, 1, 1, 1, 5,  1, 0, 0);   // 36
    add(1, 1, 1, 0, 0,  5, 0, 0);   // 37
    add(1, 1, 1, 0, 0,  4, 1, 0);   // 38

    rst_n             = 1'b0;
    aurora_channel_up = 1'b1;
    adc_acq_sm_idle   = 1'b1;
    command_sm_idle   = 1'b1;
    err_pulse         = 1'b0;
    err_code          = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("por%0d", i), 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    run_vecs(0, 34);

    // Mid-cycle reset while in ERR_OFF: pins must clear without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold%0d", i), 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_vecs(35, 38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
